// File: rtl/soc_coulomb_tracker.sv
// soc_coulomb_tracker: coulomb-counting SOC integrator with one float<->Q16.16 datapath shared across four cells
module soc_coulomb_tracker #(
    parameter int DT_SHIFT = 4,
    parameter int SOC_MAX  = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_we,
    input  logic [1:0]  init_sel,
    input  logic [31:0] init_soc,
    input  logic        sample_valid,
    output logic        sample_ready,
    input  logic [31:0] i1,
    input  logic [31:0] i2,
    input  logic [31:0] i3,
    input  logic [31:0] i4,
    output logic [31:0] soc1,
    output logic [31:0] soc2,
    output logic [31:0] soc3,
    output logic [31:0] soc4,
    output logic        soc_valid,
    output logic [3:0]  sat
);
    typedef enum logic [2:0] {IDLE, CONV, ACC, PACK, DONE} state_t;
    localparam logic signed [32:0] MAX_FX = 33'(SOC_MAX * 65536);
    state_t state_q, state_d;
    logic mode_q, mode_d;
    logic [1:0] cell_q, cell_d;
    logic [31:0] in_q[4], in_d[4];
    logic signed [31:0] cur_fx_q, cur_fx_d;
    logic [31:0] soc_fx_q[4], soc_fx_d[4];
    logic [31:0] soc_q[4], soc_d[4];
    logic [3:0] sat_q, sat_d;
    logic soc_valid_q, soc_valid_d;
    logic [31:0] f, pv, pk;
    logic [7:0] e;
    logic [30:0] sig, mag;
    logic neg, acc_lo, acc_hi;
    logic signed [31:0] conv_fx;
    logic signed [32:0] cur33, step, acc_raw;
    logic [31:0] acc_fx;
    logic [4:0] p;
    logic [22:0] mant;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cell_q      <= '0;
            in_q        <= '{default: '0};
            cur_fx_q    <= '0;
            soc_fx_q    <= '{default: '0};
            soc_q       <= '{default: '0};
            sat_q       <= '0;
            soc_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cell_q      <= cell_d;
            in_q        <= in_d;
            cur_fx_q    <= cur_fx_d;
            soc_fx_q    <= soc_fx_d;
            soc_q       <= soc_d;
            sat_q       <= sat_d;
            soc_valid_q <= soc_valid_d;
        end
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = (init_we || sample_valid) ? CONV : IDLE;
            CONV:    state_d = ACC;
            ACC:     state_d = PACK;
            PACK:    state_d = (!mode_q && cell_q != 2'd3) ? CONV : DONE;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        sample_ready = state_q == IDLE;
        soc_valid_d  = state_q == DONE;
    end
    always_comb begin
        f       = in_q[cell_q];
        e       = f[30:23];
        sig     = {7'b0, 1'b1, f[22:0]};
        mag     = (e > 8'd141) ? 31'h7fffffff : (e < 8'd111) ? 31'h0 :
                  (e >= 8'd134) ? (sig << (e - 8'd134)) : (sig >> (8'd134 - e));
        neg     = f[31] && !(e == 8'hff && f[22:0] != 23'h0);
        conv_fx = neg ? -{1'b0, mag} : {1'b0, mag};
        cur33   = {cur_fx_q[31], cur_fx_q};
        step    = cur33 >>> DT_SHIFT;
        acc_raw = mode_q ? cur33 : $signed({1'b0, soc_fx_q[cell_q]}) - step;
        acc_lo  = acc_raw < 0;
        acc_hi  = acc_raw > MAX_FX;
        acc_fx  = acc_lo ? 32'h0 : acc_hi ? MAX_FX[31:0] : acc_raw[31:0];
        pv      = soc_fx_q[cell_q];
        p       = '0;
        for (int i = 0; i < 32; i++)
            if (pv[i]) p = 5'(i);
        mant    = 23'({pv, 23'b0} >> p);
        pk      = (pv == 32'h0) ? 32'h0 : {1'b0, 8'd111 + {3'b0, p}, mant};
    end
    always_comb begin
        mode_d   = mode_q;
        cell_d   = cell_q;
        in_d     = in_q;
        cur_fx_d = cur_fx_q;
        soc_fx_d = soc_fx_q;
        soc_d    = soc_q;
        sat_d    = sat_q;
        if (state_q == IDLE && init_we) begin
            mode_d         = 1'b1;
            cell_d         = init_sel;
            in_d[init_sel] = init_soc;
        end else if (state_q == IDLE && sample_valid) begin
            mode_d = 1'b0;
            cell_d = 2'd0;
            in_d   = '{i1, i2, i3, i4};
        end else if (state_q == CONV) begin
            cur_fx_d = conv_fx;
        end else if (state_q == ACC) begin
            soc_fx_d[cell_q] = acc_fx;
            sat_d[cell_q]    = acc_lo || acc_hi;
        end else if (state_q == PACK) begin
            soc_d[cell_q] = pk;
            cell_d        = (!mode_q && cell_q != 2'd3) ? cell_q + 2'd1 : cell_q;
        end
    end
    assign soc1      = soc_q[0];
    assign soc2      = soc_q[1];
    assign soc3      = soc_q[2];
    assign soc4      = soc_q[3];
    assign sat       = sat_q;
    assign soc_valid = soc_valid_q;
endmodule

// File: doc/soc_coulomb_tracker.md
Name: soc_coulomb_tracker

Overview:
- Produces the per-cell state-of-charge words soc1..soc4 that the current-split top level consumes.
- Takes the per-cell currents i1..i4 that top level returns, integrates them by coulomb counting, and republishes updated SOC values.
- All external data is IEEE-754 single precision. Accumulation is internal signed Q16.16 fixed point.
- One shared convert/accumulate/pack datapath is time-multiplexed across the four cells by an FSM.

Parameters:
- DT_SHIFT, 4: charge step = current >>> DT_SHIFT (arithmetic shift) per accepted sample.
- SOC_MAX, 100: upper SOC clamp, integer part of Q16.16 (SOC_MAX<<16).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- init_we  in  1  load an initial SOC for one cell.
- init_sel  in  2  cell index for init (0..3 = cell1..cell4).
- init_soc  in  32  initial SOC, float.
- sample_valid  in  1  current sample present.
- sample_ready  out  1  high only in IDLE.
- i1, i2, i3, i4  in  32 each  per-cell current, float; positive = discharge.
- soc1, soc2, soc3, soc4  out  32 each  per-cell SOC, float.
- soc_valid  out  1  one-cycle pulse when an update or init completes.
- sat  out  4  bit k set if cell k+1 was clamped on its last update.

Behaviour:
- Reset values: soc1..4 = 0x00000000; internal Q16.16 registers = 0; soc_valid = 0; sat = 0; state = IDLE, so sample_ready = 1.
- A reset asserted mid-operation aborts the sequence. All state returns to reset values; a partial update is never published.
- States: IDLE, CONV, ACC, PACK, DONE.
- IDLE transitions:
  - init_we=1 takes priority and sets mode=INIT. It captures init_sel and init_soc, then goes to CONV.
  - Otherwise sample_valid=1 sets mode=SAMPLE. It captures i1..i4 into holding registers, sets cell=0, then goes to CONV.
  - When both are asserted together, init wins and the sample is not accepted. The source must hold sample_valid.
- Inputs are captured only on acceptance. Changes to i1..i4 or init_soc during CONV..DONE have no effect.
- CONV: convert the selected float to signed Q16.16 (one cycle).
  - Truncate toward zero.
  - |x| < 2^-16, zero, or denormal -> 0.
  - Exponent > 141 (|x| >= 2^15), Inf, or NaN -> saturate to 0x7FFFFFFF, or 0x80000001 if the sign is negative. NaN is always treated as positive.
- ACC (one cycle):
  - SAMPLE mode: next = soc_fx[cell] - (cur_fx >>> DT_SHIFT), computed 33-bit signed with no wrap.
  - INIT mode: next = cur_fx.
  - Clamp next to [0, SOC_MAX<<16]. sat[cell] = 1 if clamped, else 0. Write soc_fx[cell].
- PACK: convert unsigned Q16.16 soc_fx[cell] to float (one cycle), updating only that cell's socN output.
  - 0 -> 0x00000000.
  - Otherwise: sign 0, exponent = 127 + (msb_index - 16), mantissa = the next 23 bits, truncated (round toward zero), zero-filled when fewer bits exist.
- After PACK:
  - SAMPLE mode with cell < 3: cell++ and return to CONV.
  - Otherwise go to DONE.
- DONE: soc_valid = 1 for exactly this cycle, then IDLE.
- Latency from acceptance edge to soc_valid: SAMPLE = 13 cycles (3 per cell x4, +1); INIT = 4 cycles.
- socN outputs update cell by cell during the sequence. They are only coherent when soc_valid=1 or in IDLE.

Test Plan:
- Reset, then four inits: 0x3f800000, 0x40000000, 0x40400000, 0x40800000 to cells 0..3.
  - Each gives a soc_valid pulse 4 cycles after its init_we.
  - Expect soc1..4 = 1.0, 2.0, 3.0, 4.0, with sat=0.
- From that state, sample i1..i4 = 0x41000000 (8.0).
  - Expect soc_valid 13 cycles later.
  - Expect soc1..4 = 0x3f000000, 0x3fc00000, 0x40200000, 0x40600000.
  - Expect sample_ready=0 throughout the sequence.
- Charging: re-init cell1 to 1.0, then sample all currents = 0xc1200000 (-10.0).
  - Expect soc1 = 0x3fd00000 (1.625).
- Low clamp: soc1=0.5, i1=0x41800000 (16.0) -> soc1=0x00000000, sat[0]=1.
  - Next sample with i1=0 -> soc1 stays 0, sat[0]=0.
- High clamp and NaN:
  - init cell2 = 0x42c80000 (100.0), i2=0xc2000000 (-32.0) -> soc2 stays 0x42c80000, sat[1]=1.
  - i3=0x7fc00000 (NaN) -> soc3=0, sat[2]=1.
- Collisions and reset:
  - Assert init_we and sample_valid in the same IDLE cycle -> only the init occurs (soc_valid after 4 cycles); the sample is accepted after the return to IDLE.
  - Assert rst at cycle 6 of a sample sequence -> all outputs 0 next cycle, no soc_valid pulse.
